dpram_portb_arbiter: RTL

- Round-robin arbiter and sequencer that shares port B of the CDC dual-port RAM among NUM_REQ requesters in the clk_b domain.
- Accepts read and posted-write requests and drives the RAM port-B pins with one-cycle command pulses.
- Holds off writes while the RAM's cross-domain write handshake is pending; reads continue during that time.
- Tracks read latency and returns each read result to the requester that issued it.

---
 rtl/dpram_portb_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dpram_portb_arbiter.sv
// Purpose: round-robin arbiter/sequencer sharing port B of the CDC dual-port RAM among NUM_REQ clk_b requesters.
// Latency: gnt and RAM command one cycle after an eligible request; read data returned (rvalid/rdata) two cycles after gnt.
// Backpressure: requesters hold req until gnt; writes stall while ram_wr_busy or wr_lock is set, reads keep flowing.
//
// Ports:
//   clk_b, rst_b            port-B clock, asynchronous active-high reset
//   req/req_we              per-requester request and direction (1 = posted write)
//   req_addr/req_din        packed per-requester address and write data
//   gnt                     one-hot, one-cycle accept pulse
//   rvalid/rdata            one-hot read-return pulse and its data (rdata holds otherwise)
//   ram_we_b/addr_b/din_b   registered RAM port-B command
//   ram_dout_b              RAM read data, valid the cycle after the command
//   ram_wr_busy             RAM cross-domain write still in flight
module dpram_portb_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                           clk_b,
    input  logic                           rst_b,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_din,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           ram_we_b,
    output logic [ADDR_WIDTH-1:0]          ram_addr_b,
    output logic [DATA_WIDTH-1:0]          ram_din_b,
    input  logic [DATA_WIDTH-1:0]          ram_dout_b,
    input  logic                           ram_wr_busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    // (base + k) mod NUM_REQ for k < NUM_REQ, without a divider
    function automatic idx_t wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return idx_t'(s);
    endfunction

    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    idx_t                  rr_ptr_q, rr_ptr_d;
    logic                  wr_lock_q, wr_lock_d;
    logic                  rd1_vld_q, rd1_vld_d;
    idx_t                  rd1_idx_q, rd1_idx_d;
    logic                  rd2_vld_q, rd2_vld_d;
    idx_t                  rd2_idx_q, rd2_idx_d;

    logic [NUM_REQ-1:0]    elig;
    logic                  win_vld;
    idx_t                  win_idx;

    // A requester sees its gnt during the grant cycle and still has req up;
    // masking with gnt_q stops it from being granted a second time.
    // wr_lock_q covers the cycle before ram_wr_busy reflects our own write.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] && !gnt_q[i] &&
                      (!req_we[i] || (!ram_wr_busy && !wr_lock_q));
        end
    end

    // First eligible requester at or after rr_ptr, ascending with wrap.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_vld && elig[wrap_idx(int'(rr_ptr_q), k)]) begin
                win_vld = 1'b1;
                win_idx = wrap_idx(int'(rr_ptr_q), k);
            end
        end
    end

    always_comb begin
        gnt_d      = '0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rr_ptr_d   = rr_ptr_q;
        wr_lock_d  = 1'b0;
        rd1_vld_d  = 1'b0;
        rd1_idx_d  = rd1_idx_q;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            ram_we_d       = req_we[win_idx];
            ram_addr_d     = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            ram_din_d      = req_din[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            rr_ptr_d       = wrap_idx(int'(win_idx), 1);
            wr_lock_d      = req_we[win_idx];
            rd1_vld_d      = !req_we[win_idx];
            rd1_idx_d      = win_idx;
        end

        // Stage 1 is live in the grant cycle, stage 2 in the cycle the RAM
        // presents dout; the result is registered out one cycle later.
        rd2_vld_d = rd1_vld_q;
        rd2_idx_d = rd1_idx_q;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        if (rd2_vld_q) begin
            rvalid_d[rd2_idx_q] = 1'b1;
            rdata_d             = ram_dout_b;
        end
    end

    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            rr_ptr_q   <= '0;
            wr_lock_q  <= 1'b0;
            rd1_vld_q  <= 1'b0;
            rd1_idx_q  <= '0;
            rd2_vld_q  <= 1'b0;
            rd2_idx_q  <= '0;
        end else begin
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_lock_q  <= wr_lock_d;
            rd1_vld_q  <= rd1_vld_d;
            rd1_idx_q  <= rd1_idx_d;
            rd2_vld_q  <= rd2_vld_d;
            rd2_idx_q  <= rd2_idx_d;
        end
    end

    assign gnt        = gnt_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign ram_we_b   = ram_we_q;
    assign ram_addr_b = ram_addr_q;
    assign ram_din_b  = ram_din_q;

endmodule
